// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mm_pkg
//  Description : Shared types and constants for the mm display path:
//                digit index type, active-low 7-segment glyph table and
//                special segment patterns (blank, dash).
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package mm_pkg;

   typedef logic [1:0] digit_idx_t;

   // Active-low segment patterns, bit0 = a ... bit6 = g
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   localparam logic [6:0] SEG_LUT [0:9] = '{
      7'b1000000,   // 0
      7'b1111001,   // 1
      7'b0100100,   // 2
      7'b0110000,   // 3
      7'b0011001,   // 4
      7'b0010010,   // 5
      7'b0000010,   // 6
      7'b1111000,   // 7
      7'b0000000,   // 8
      7'b0010000    // 9
   };

endpackage
`default_nettype wire

// File: rtl/mm_bcd_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module      : mm_bcd_to_seg7
//  Description : Combinational BCD nibble to active-low 7-segment decoder.
//                Non-decimal nibbles (A-F) render as a dash.
//  Ports       : nib_i [3:0]  BCD nibble in
//                seg_o [6:0]  active-low segments, bit0 = a ... bit6 = g
//  Revision    : 1.0  initial release
// ============================================================================
module mm_bcd_to_seg7
   import mm_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_DASH;
      if (nib_i < 4'd10) begin
         seg_o = SEG_LUT[nib_i];
      end
   end

endmodule
`default_nettype wire

// File: rtl/mm_seg7_disp.sv
`default_nettype none
// ============================================================================
//  Module      : mm_seg7_disp
//  Description : Latches a 4-digit BCD result (hold / clear) and scans it
//                onto a 4-digit common-anode 7-segment display with
//                leading-zero blanking, selectable decimal point and dash
//                indication for non-decimal nibbles. All pins registered.
//  Ports       : clk, rst_n          clock, async active-low reset
//                clr_i               clear latched value
//                hold_i              freeze latched value, drop updates
//                lz_blank_i          enable leading-zero blanking
//                dp_sel_i [1:0]      0 = no DP, k = DP on digit k
//                din_bcd_i [15:0]    BCD value, [3:0] = rightmost digit
//                din_update_i        single-cycle valid strobe
//                disp_val_o [15:0]   latched display value
//                an_o [3:0]          anode enables, active low
//                seg_o [6:0]         segments, active low
//                dp_o                decimal point, active low
//  Revision    : 1.0  initial release
// ============================================================================
module mm_seg7_disp
   import mm_pkg::*;
#(
   parameter int REFRESH_DIV = 100000
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr_i,
   input  logic        hold_i,
   input  logic        lz_blank_i,
   input  logic [1:0]  dp_sel_i,
   input  logic [15:0] din_bcd_i,
   input  logic        din_update_i,
   output logic [15:0] disp_val_o,
   output logic [3:0]  an_o,
   output logic [6:0]  seg_o,
   output logic        dp_o
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   logic [15:0]      disp_val_q, disp_val_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   digit_idx_t       idx_q, idx_d;
   logic [3:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;

   logic             w_tick;
   logic [3:0]       w_nib;
   logic [6:0]       w_glyph;
   logic [3:0]       w_zero;
   logic [3:0]       w_lead;
   logic             w_blank;

   // Single decoder on the currently scanned nibble
   assign w_nib = disp_val_q[{idx_q, 2'b00} +: 4];

   mm_bcd_to_seg7 u_dec (
      .nib_i (w_nib),
      .seg_o (w_glyph)
   );

   genvar g;
   generate
      for (g = 0; g < 4; g++) begin : g_zero
         assign w_zero[g] = (disp_val_q[4*g +: 4] == 4'd0);
      end
   endgenerate

   // w_lead[i]: every nibble from the leftmost down to digit i is zero.
   // Digit 0 never qualifies, so it is never blanked.
   assign w_lead[3] = w_zero[3];
   assign w_lead[2] = w_lead[3] & w_zero[2];
   assign w_lead[1] = w_lead[2] & w_zero[1];
   assign w_lead[0] = 1'b0;

   // Digits at or right of the DP digit carry significance and stay lit
   assign w_blank = lz_blank_i && w_lead[idx_q] &&
                    ((dp_sel_i == 2'd0) || (idx_q > dp_sel_i));

   assign w_tick = (cnt_q == CNT_LAST);

   always_comb begin
      // Latch: clear beats update, update is dropped while holding
      disp_val_d = disp_val_q;
      if (clr_i) begin
         disp_val_d = 16'h0000;
      end else if (din_update_i && !hold_i) begin
         disp_val_d = din_bcd_i;
      end

      cnt_d = w_tick ? '0 : cnt_q + 1'b1;
      idx_d = w_tick ? idx_q + 2'd1 : idx_q;

      an_d  = ~(4'b0001 << idx_q);
      seg_d = w_blank ? SEG_BLANK : w_glyph;
      dp_d  = !((dp_sel_i != 2'd0) && (idx_q == dp_sel_i));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_val_q <= 16'h0000;
         cnt_q      <= '0;
         idx_q      <= 2'd0;
         an_q       <= 4'hF;
         seg_q      <= SEG_BLANK;
         dp_q       <= 1'b1;
      end else begin
         disp_val_q <= disp_val_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
      end
   end

   assign disp_val_o = disp_val_q;
   assign an_o       = an_q;
   assign seg_o      = seg_q;
   assign dp_o       = dp_q;

endmodule
`default_nettype wire
